// File: rtl/irig_pkg.sv
// Shared symbol codes, FSM states and millisecond thresholds for the IRIG-B symbol classifier.
package irig_pkg;

  localparam logic [2:0] SYM_MARK = 3'b100;
  localparam logic [2:0] SYM_D1   = 3'b010;
  localparam logic [2:0] SYM_D0   = 3'b001;
  localparam logic [2:0] SYM_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_IDLE     = 2'd1,
    ST_HIGH     = 2'd2,
    ST_LOW      = 2'd3
  } irig_state_e;

  // Window edges in tenths of a millisecond.
  localparam int unsigned T_MIN_TENTHS     = 10;
  localparam int unsigned T_D1_TENTHS      = 35;
  localparam int unsigned T_MARK_TENTHS    = 65;
  localparam int unsigned T_HI_MAX_TENTHS  = 90;
  localparam int unsigned T_LO_MAX_TENTHS  = 95;
  localparam int unsigned T_PER_MAX_TENTHS = 105;

  function automatic longint unsigned tenthsToCycles(input int unsigned tenths,
                                                     input int unsigned clkHz);
    return (64'(tenths) * 64'(clkHz)) / 64'd10000;
  endfunction

endpackage

// File: rtl/irig_input_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter on the raw IRIG-B pin.
module irig_input_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(FILT_LEN - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] run_q, run_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      run_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      run_q   <= run_d;
    end
  end

  // Any sample that agrees with the current level restarts the run.
  always_comb begin
    level_d = level_q;
    run_d   = run_q;
    if (sync_q[1] == level_q) begin
      run_d = '0;
    end else if (run_q == RUN_LAST) begin
      level_d = ~level_q;
      run_d   = '0;
    end else begin
      run_d = run_q + CW'(1);
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/irig_symbol_classifier.sv
// IRIG-B pulse-width classifier: filtered level to D0/D1/MARK symbol strobes, frame start and LOS.
// Optional period supervision is enabled by defining IRIG_PERIOD_CHECK_EN.
module irig_symbol_classifier
  import irig_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 10000000,
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       irigb,
  output logic       sym_valid,
  output logic [2:0] sym_code,
  output logic       sym_err,
  output logic       edge_stb,
  output logic       frame_start,
  output logic       los
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] T_MIN     = CNT_W'(tenthsToCycles(T_MIN_TENTHS, CLK_HZ));
  localparam logic [CNT_W-1:0] T_D1      = CNT_W'(tenthsToCycles(T_D1_TENTHS, CLK_HZ));
  localparam logic [CNT_W-1:0] T_MARK    = CNT_W'(tenthsToCycles(T_MARK_TENTHS, CLK_HZ));
  localparam logic [CNT_W-1:0] T_HI_MAX  = CNT_W'(tenthsToCycles(T_HI_MAX_TENTHS, CLK_HZ));
  localparam logic [CNT_W-1:0] T_LO_MAX  = CNT_W'(tenthsToCycles(T_LO_MAX_TENTHS, CLK_HZ));

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic        f;
  logic        fPrev_q;
  logic        rise, fall;

  irig_state_e      state_q, state_d;
  logic [CNT_W-1:0] hiCnt_q, hiCnt_d;
  logic [CNT_W-1:0] loCnt_q, loCnt_d;
  logic             symValid_q, symValid_d;
  logic [2:0]       symCode_q, symCode_d;
  logic             symErr_q, symErr_d;
  logic             edgeStb_q, edgeStb_d;
  logic             frameStart_q, frameStart_d;
  logic             los_q, los_d;
  logic             prevMark_q, prevMark_d;

  logic             emit;
  logic [2:0]       emitCode;
  logic [2:0]       classCode;
  logic             periodFault;

  irig_input_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (irigb),
    .level_o (f)
  );

  assign rise = f & ~fPrev_q;
  assign fall = ~f & fPrev_q;

`ifdef IRIG_PERIOD_CHECK_EN
  localparam logic [CNT_W-1:0] T_PER_MIN = T_LO_MAX;
  localparam logic [CNT_W-1:0] T_PER_MAX = CNT_W'(tenthsToCycles(T_PER_MAX_TENTHS, CLK_HZ));

  logic [CNT_W-1:0] perCnt_q, perCnt_d;
  logic             perBad_q, perBad_d;

  // A rise out of IDLE has no preceding edge to measure against, so only rises from LOW are judged.
  always_comb begin
    perCnt_d = satInc(perCnt_q);
    perBad_d = perBad_q;
    if (rise && (state_q == ST_IDLE || state_q == ST_LOW)) begin
      perCnt_d = CNT_ONE;
      perBad_d = (state_q == ST_LOW) && ((perCnt_q < T_PER_MIN) || (perCnt_q > T_PER_MAX));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perCnt_q <= '0;
      perBad_q <= 1'b0;
    end else begin
      perCnt_q <= perCnt_d;
      perBad_q <= perBad_d;
    end
  end

  assign periodFault = perBad_q;
`else
  assign periodFault = 1'b0;
`endif

  always_comb begin
    classCode = SYM_NONE;
    if (hiCnt_q >= T_MIN && hiCnt_q < T_D1) begin
      classCode = SYM_D0;
    end else if (hiCnt_q >= T_D1 && hiCnt_q < T_MARK) begin
      classCode = SYM_D1;
    end else if (hiCnt_q >= T_MARK && hiCnt_q < T_HI_MAX) begin
      classCode = SYM_MARK;
    end
  end

  // Every symbol, error or not, funnels through emit so LOS and the MARK history stay consistent.
  always_comb begin
    state_d      = state_q;
    hiCnt_d      = hiCnt_q;
    loCnt_d      = loCnt_q;
    los_d        = los_q;
    prevMark_d   = prevMark_q;
    symValid_d   = 1'b0;
    symCode_d    = SYM_NONE;
    symErr_d     = 1'b0;
    edgeStb_d    = 1'b0;
    frameStart_d = 1'b0;
    emit         = 1'b0;
    emitCode     = SYM_NONE;

    case (state_q)
      ST_WAIT_LOW: begin
        if (!f) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (rise) begin
          hiCnt_d   = CNT_ONE;
          edgeStb_d = 1'b1;
          state_d   = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          emit     = 1'b1;
          emitCode = periodFault ? SYM_NONE : classCode;
          loCnt_d  = CNT_ONE;
          state_d  = ST_LOW;
        end else if (hiCnt_q >= T_HI_MAX) begin
          emit    = 1'b1;
          state_d = ST_WAIT_LOW;
        end else begin
          hiCnt_d = satInc(hiCnt_q);
        end
      end
      ST_LOW: begin
        if (rise) begin
          hiCnt_d   = CNT_ONE;
          edgeStb_d = 1'b1;
          state_d   = ST_HIGH;
        end else if (loCnt_q >= T_LO_MAX) begin
          emit    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          loCnt_d = satInc(loCnt_q);
        end
      end
      default: state_d = ST_WAIT_LOW;
    endcase

    if (emit) begin
      symValid_d   = 1'b1;
      symCode_d    = emitCode;
      symErr_d     = (emitCode == SYM_NONE);
      frameStart_d = (emitCode == SYM_MARK) && prevMark_q;
      prevMark_d   = (emitCode == SYM_MARK);
      los_d        = (emitCode == SYM_NONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_LOW;
      fPrev_q      <= 1'b1;
      hiCnt_q      <= '0;
      loCnt_q      <= '0;
      symValid_q   <= 1'b0;
      symCode_q    <= SYM_NONE;
      symErr_q     <= 1'b0;
      edgeStb_q    <= 1'b0;
      frameStart_q <= 1'b0;
      los_q        <= 1'b1;
      prevMark_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fPrev_q      <= f;
      hiCnt_q      <= hiCnt_d;
      loCnt_q      <= loCnt_d;
      symValid_q   <= symValid_d;
      symCode_q    <= symCode_d;
      symErr_q     <= symErr_d;
      edgeStb_q    <= edgeStb_d;
      frameStart_q <= frameStart_d;
      los_q        <= los_d;
      prevMark_q   <= prevMark_d;
    end
  end

  assign sym_valid   = symValid_q;
  assign sym_code    = symCode_q;
  assign sym_err     = symErr_q;
  assign edge_stb    = edgeStb_q;
  assign frame_start = frameStart_q;
  assign los         = los_q;

endmodule

// File: tb/tb_irig_symbol_classifier.sv
// Directed bench for irig_symbol_classifier at a scaled clock (CLK_HZ=10000, so 1 ms = 10 cycles).
module tb_irig_symbol_classifier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       irigb;
  logic       sym_valid;
  logic [2:0] sym_code;
  logic       sym_err;
  logic       edge_stb;
  logic       frame_start;
  logic       los;

  int assertCount = 0;
  int failCount   = 0;

  int         symCount  = 0;
  int         edgeCount = 0;
  int         fsCount   = 0;
  logic [2:0] lastCode  = 3'b000;
  logic       lastErr   = 1'b0;
  logic       lastFs    = 1'b0;

  irig_symbol_classifier #(
    .CLK_HZ   (10000),
    .FILT_LEN (4),
    .CNT_W    (18)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irigb       (irigb),
    .sym_valid   (sym_valid),
    .sym_code    (sym_code),
    .sym_err     (sym_err),
    .edge_stb    (edge_stb),
    .frame_start (frame_start),
    .los         (los)
  );

  always #5 clk = ~clk;

  // Strobe log sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (edge_stb) edgeCount++;
      if (sym_valid) begin
        symCount++;
        lastCode = sym_code;
        lastErr  = sym_err;
        lastFs   = frame_start;
        if (frame_start) fsCount++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full period: high for hiCycles, then low so the next call rises hiCycles+loCycles later.
  task automatic applyStimulus(input int hiCycles, input int loCycles);
    @(posedge clk);
    #1 irigb = 1'b1;
    repeat (hiCycles) @(posedge clk);
    #1 irigb = 1'b0;
    repeat (loCycles - 1) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    irigb = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_sym_valid", sym_valid, 1'b0);
    checkOutput("rst_sym_code", sym_code, 3'b000);
    checkOutput("rst_sym_err", sym_err, 1'b0);
    checkOutput("rst_edge_stb", edge_stb, 1'b0);
    checkOutput("rst_frame_start", frame_start, 1'b0);
    checkOutput("rst_los", los, 1'b1);

    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    checkOutput("idle_los", los, 1'b1);
    checkOutput("idle_sym_count", symCount, 0);

    // D0 with exact latencies: edge_stb 7 cycles after the rise, symbol 7 cycles after the fall.
    @(posedge clk);
    #1 irigb = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("edge_stb_early", edge_stb, 1'b0);
    @(negedge clk);
    checkOutput("edge_stb_lat7", edge_stb, 1'b1);
    @(negedge clk);
    checkOutput("edge_stb_oneshot", edge_stb, 1'b0);
    repeat (12) @(posedge clk);
    #1 irigb = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("d0_valid_early", sym_valid, 1'b0);
    @(negedge clk);
    checkOutput("d0_valid", sym_valid, 1'b1);
    checkOutput("d0_code", sym_code, 3'b001);
    checkOutput("d0_err", sym_err, 1'b0);
    checkOutput("d0_los_clear", los, 1'b0);
    checkOutput("d0_frame_start", frame_start, 1'b0);
    repeat (72) @(posedge clk);

    applyStimulus(50, 50);
    checkOutput("d1_code", lastCode, 3'b010);
    checkOutput("d1_err", lastErr, 1'b0);
    applyStimulus(80, 20);
    checkOutput("mark_code", lastCode, 3'b100);
    checkOutput("mark_after_d1_fs", lastFs, 1'b0);
    applyStimulus(35, 65);
    checkOutput("boundary_35_d1", lastCode, 3'b010);
    applyStimulus(34, 66);
    checkOutput("boundary_34_d0", lastCode, 3'b001);
    checkOutput("sym_count_5", symCount, 5);

    applyStimulus(80, 20);
    checkOutput("mm_first_fs", lastFs, 1'b0);
    applyStimulus(80, 20);
    checkOutput("mm_second_fs", lastFs, 1'b1);
    checkOutput("mm_second_code", lastCode, 3'b100);
    applyStimulus(20, 80);
    checkOutput("mm_d0_fs", lastFs, 1'b0);
    checkOutput("mm_fs_count", fsCount, 1);

    applyStimulus(80, 20);
    applyStimulus(50, 50);
    applyStimulus(80, 20);
    checkOutput("mdm_fs", lastFs, 1'b0);
    checkOutput("mdm_fs_count", fsCount, 1);
    checkOutput("mdm_code", lastCode, 3'b100);

    // D1 with a 2-cycle low glitch while high and a 3-cycle high glitch while low.
    @(posedge clk);
    #1 irigb = 1'b1;
    repeat (20) @(posedge clk);
    #1 irigb = 1'b0;
    repeat (2) @(posedge clk);
    #1 irigb = 1'b1;
    repeat (28) @(posedge clk);
    #1 irigb = 1'b0;
    repeat (20) @(posedge clk);
    #1 irigb = 1'b1;
    repeat (3) @(posedge clk);
    #1 irigb = 1'b0;
    repeat (26) @(posedge clk);
    checkOutput("glitch_edge_count", edgeCount, 12);
    checkOutput("glitch_sym_count", symCount, 12);
    checkOutput("glitch_code", lastCode, 3'b010);
    checkOutput("glitch_err", lastErr, 1'b0);

    repeat (110) @(posedge clk);
    checkOutput("lo_timeout_count", symCount, 13);
    checkOutput("lo_timeout_err", lastErr, 1'b1);
    checkOutput("lo_timeout_code", lastCode, 3'b000);
    checkOutput("lo_timeout_los", los, 1'b1);

    applyStimulus(20, 80);
    checkOutput("recover_code", lastCode, 3'b001);
    checkOutput("recover_los", los, 1'b0);
    checkOutput("recover_count", symCount, 14);

    // Line stuck high for 12 ms: error when the high count reaches 90.
    @(posedge clk);
    #1 irigb = 1'b1;
    repeat (97) @(negedge clk);
    checkOutput("hi_timeout_early", sym_valid, 1'b0);
    @(negedge clk);
    checkOutput("hi_timeout_valid", sym_valid, 1'b1);
    checkOutput("hi_timeout_err", sym_err, 1'b1);
    checkOutput("hi_timeout_code", sym_code, 3'b000);
    checkOutput("hi_timeout_los", los, 1'b1);
    repeat (23) @(posedge clk);
    #1 irigb = 1'b0;
    repeat (30) @(posedge clk);
    checkOutput("hi_timeout_no_extra_sym", symCount, 15);
    checkOutput("hi_timeout_edge_count", edgeCount, 14);
    applyStimulus(20, 80);
    checkOutput("after_hi_timeout_code", lastCode, 3'b001);
    checkOutput("after_hi_timeout_los", los, 1'b0);
    checkOutput("after_hi_timeout_count", symCount, 16);

    // Reset in the middle of a high pulse, released while the line is still high.
    @(posedge clk);
    #1 irigb = 1'b1;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_sym_valid", sym_valid, 1'b0);
    checkOutput("midrst_los", los, 1'b1);
    checkOutput("midrst_edge_stb", edge_stb, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1 irigb = 1'b0;
    repeat (60) @(posedge clk);
    checkOutput("midrst_no_sym", symCount, 16);
    checkOutput("midrst_edge_count", edgeCount, 16);
    checkOutput("midrst_los_held", los, 1'b1);
    applyStimulus(20, 80);
    checkOutput("midrst_next_code", lastCode, 3'b001);
    checkOutput("midrst_next_count", symCount, 17);
    checkOutput("midrst_next_los", los, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
